// File: rtl/ahb_apb_bridge_pkg.sv
// Shared AHB definitions for the AHB-to-APB bridge: HTRANS/HRESP encodings,
// bridge FSM state encoding and the slave-index field width.
package ahb_apb_bridge_pkg;

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_e;

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_dec.sv
// Slave address decode for the AHB-to-APB bridge: index and miss flag from the
// HADDR select field, one-hot PSEL pattern from the registered index.
module ahb_apb_dec
    import ahb_apb_bridge_pkg::*;
#(
    parameter int NUM_SLV = 16
) (
    input  logic [IDX_W-1:0]   addr_sel,
    output logic [IDX_W-1:0]   addr_idx,
    output logic               addr_miss,
    input  logic [IDX_W-1:0]   sel_idx,
    output logic [NUM_SLV-1:0] sel_onehot
);

    assign addr_idx = addr_sel;

    // With all 16 slaves populated every index is valid.
    generate
        if (NUM_SLV < 16) begin : g_miss
            assign addr_miss = (addr_sel >= IDX_W'(NUM_SLV));
        end else begin : g_full
            assign addr_miss = 1'b0;
        end
    endgenerate

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_onehot[i] = (sel_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-lite to APB bridge with up to 16 slaves selected by HADDR[SEL_LSB+3:SEL_LSB].
// Define AHB_APB_ERR_RESP_EN to turn PSLVERR and decode misses into AHB ERROR responses.
//
// state  | meaning
// IDLE   | no APB transfer; ready to accept
// WAIT   | write accepted; capturing HWDATA into PWDATA
// SETUP  | APB setup phase (PSEL=1, PENABLE=0)
// ACCESS | APB access phase; held until selected PREADY
// ERR1   | first ERROR response cycle (HREADY_o=0)
// ERR2   | second ERROR response cycle (HREADY_o=1)
module ahb_apb_bridge
    import ahb_apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 16,
    parameter int SEL_LSB = 28
) (
    input  logic                      HCLK,
    input  logic                      HRST,
    input  logic                      HSEL,
    input  logic                      HWRITE,
    input  logic                      HREADY,
    input  logic [1:0]                HTRANS,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [DATA_W-1:0]         HWDATA,
    output logic                      HREADY_o,
    output logic [1:0]                HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    bridge_state_e        state_q;
    bridge_state_e        state_d;
    bridge_state_e        next_xfer;
    logic                 can_accept;
    logic                 accept;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_miss;
    logic [NUM_SLV-1:0]   sel_onehot;
    logic                 pready_sel;
    logic                 pslverr_sel;
    logic                 slv_err;
    logic [DATA_W-1:0]    prdata_sel;

    ahb_apb_dec #(
        .NUM_SLV    (NUM_SLV)
    ) u_dec (
        .addr_sel   (HADDR[SEL_LSB +: IDX_W]),
        .addr_idx   (dec_idx),
        .addr_miss  (dec_miss),
        .sel_idx    (idx_q),
        .sel_onehot (sel_onehot)
    );

    assign accept = HSEL & HREADY & htrans_active(HTRANS);

    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pready_sel  = PREADY[i];
                pslverr_sel = PSLVERR[i];
                prdata_sel  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef AHB_APB_ERR_RESP_EN
    assign slv_err = pslverr_sel;
`else
    logic unused_pslverr;
    assign unused_pslverr = pslverr_sel;
    assign slv_err        = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        next_xfer = ST_IDLE;
        if (accept) begin
            if (dec_miss) begin
`ifdef AHB_APB_ERR_RESP_EN
                next_xfer = ST_ERR1;
`else
                next_xfer = ST_IDLE;
`endif
            end else if (HWRITE) begin
                next_xfer = ST_WAIT;
            end else begin
                next_xfer = ST_SETUP;
            end
        end

        state_d    = state_q;
        can_accept = 1'b0;
        HREADY_o   = 1'b0;
        HRESP      = HRESP_OKAY;
        HRDATA     = '0;
        PSEL       = '0;
        PENABLE    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d    = next_xfer;
                can_accept = 1'b1;
                HREADY_o   = 1'b1;
            end
            ST_WAIT: begin
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                PSEL    = sel_onehot;
                HRDATA  = prdata_sel;
            end
            ST_ACCESS: begin
                PSEL     = sel_onehot;
                PENABLE  = 1'b1;
                HRDATA   = prdata_sel;
                HREADY_o = pready_sel & ~slv_err;
                // A completing access doubles as the next address phase.
                if (pready_sel) begin
                    if (slv_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d    = next_xfer;
                        can_accept = 1'b1;
                    end
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                HRESP   = HRESP_ERROR;
            end
            ST_ERR2: begin
                state_d    = next_xfer;
                can_accept = 1'b1;
                HREADY_o   = 1'b1;
                HRESP      = HRESP_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            idx_q  <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else begin
            if (accept && can_accept) begin
                idx_q  <= dec_idx;
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            // HWDATA belongs to the data phase, one cycle after acceptance.
            if (state_q == ST_WAIT) begin
                PWDATA <= HWDATA;
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Scoreboard bench for ahb_apb_bridge (4 slaves); AHB_APB_ERR_RESP_EN selects
// which error-path expectations apply.
module tb_ahb_apb_bridge;
    import ahb_apb_bridge_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic              hclk = 1'b0;
    logic              hrst;
    logic              hsel;
    logic              hwrite;
    logic              hready;
    logic [1:0]        htrans;
    logic [AW-1:0]     haddr;
    logic [DW-1:0]     hwdata;
    logic              hready_o;
    logic [1:0]        hresp;
    logic [DW-1:0]     hrdata;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic              penable;
    logic [NS-1:0]     psel;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready;
    logic [NS-1:0]     pslverr;

    always #5 hclk = ~hclk;
    assign hready = hready_o;

    ahb_apb_bridge #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .NUM_SLV (NS),
        .SEL_LSB (28)
    ) dut (
        .HCLK     (hclk),
        .HRST     (hrst),
        .HSEL     (hsel),
        .HWRITE   (hwrite),
        .HREADY   (hready),
        .HTRANS   (htrans),
        .HADDR    (haddr),
        .HWDATA   (hwdata),
        .HREADY_o (hready_o),
        .HRESP    (hresp),
        .HRDATA   (hrdata),
        .PADDR    (paddr),
        .PWDATA   (pwdata),
        .PWRITE   (pwrite),
        .PENABLE  (penable),
        .PSEL     (psel),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic dphase = 1'b0;

    int exp_ps[8] = '{1, 1, 2, 2, 0, 4, 4, 0};
    int exp_pe[8] = '{0, 1, 0, 1, 0, 0, 1, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one address phase, holds it until accepted, then drives the write data phase.
    task automatic issue(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] tr, input logic push,
                         input logic [31:0] exp_rd, input logic [1:0] exp_resp);
        exp_t e;
        int   n;
        if (push) begin
            e.is_read = ~w;
            e.rdata   = exp_rd;
            e.resp    = exp_resp;
            sb.push_back(e);
        end
        hsel   = 1'b1;
        htrans = tr;
        haddr  = addr;
        hwrite = w;
        n = 0;
        forever begin
            @(negedge hclk);
            if (hready_o) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL issue_timeout: addr 0x%0h never accepted", addr);
                break;
            end
        end
        @(posedge hclk);
        #1;
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        if (w) hwdata = wd;
    endtask

    // Monitor: tracks AHB data phases and checks each completion against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (hrst) begin
                dphase = 1'b0;
            end else begin
                if (dphase && hready_o) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected: completion with empty queue at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("sb_hresp", 32'(hresp), 32'(e.resp));
                        if (e.is_read) check("sb_hrdata", hrdata, e.rdata);
                    end
                    dphase = 1'b0;
                end
                if (hready_o && hsel && htrans[1]) dphase = 1'b1;
            end
        end
    end

    initial begin
        hrst    = 1'b1;
        hsel    = 1'b0;
        hwrite  = 1'b0;
        htrans  = HTRANS_IDLE;
        haddr   = '0;
        hwdata  = '0;
        prdata  = {32'hA5A5_0001, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        pready  = 4'hF;
        pslverr = 4'h0;

        repeat (3) @(posedge hclk);
        #1;
        @(negedge hclk);
        check("rst_hready", 32'(hready_o), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        @(posedge hclk);
        #1;
        hrst = 1'b0;
        repeat (2) @(posedge hclk);
        #1;

        // Zero-wait read from slave 3
        issue(1'b0, 32'h3000_0010, 32'h0, HTRANS_NONSEQ, 1'b1, 32'hA5A5_0001, HRESP_OKAY);
        @(negedge hclk);
        check("rd_setup_psel", 32'(psel), 32'h8);
        check("rd_setup_penable", 32'(penable), 32'd0);
        check("rd_setup_hready", 32'(hready_o), 32'd0);
        check("rd_setup_paddr", paddr, 32'h3000_0010);
        check("rd_setup_pwrite", 32'(pwrite), 32'd0);
        @(negedge hclk);
        check("rd_access_psel", 32'(psel), 32'h8);
        check("rd_access_penable", 32'(penable), 32'd1);
        check("rd_access_hready", 32'(hready_o), 32'd1);
        repeat (2) @(posedge hclk);
        #1;

        // Write to slave 1 with three wait states
        pready = 4'b1101;
        issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, HTRANS_NONSEQ, 1'b1, 32'h0, HRESP_OKAY);
        @(negedge hclk);
        check("wr_wait_hready", 32'(hready_o), 32'd0);
        check("wr_wait_psel", 32'(psel), 32'd0);
        @(negedge hclk);
        check("wr_setup_psel", 32'(psel), 32'h2);
        check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_setup_pwrite", 32'(pwrite), 32'd1);
        check("wr_setup_paddr", paddr, 32'h1000_0004);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                @(posedge hclk);
                #1;
                pready[1] = 1'b1;
            end
            @(negedge hclk);
            check("wr_access_penable", 32'(penable), 32'd1);
            check("wr_access_hready", 32'(hready_o), (k == 3) ? 32'd1 : 32'd0);
        end
        @(negedge hclk);
        check("wr_done_penable", 32'(penable), 32'd0);
        pready = 4'hF;
        repeat (2) @(posedge hclk);
        #1;

        // Burst: read slave 0, read slave 1, write slave 2
        issue(1'b0, 32'h0000_0000, 32'h0, HTRANS_NONSEQ, 1'b1, 32'h1111_0000, HRESP_OKAY);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge hclk);
                    check("burst_psel", 32'(psel), exp_ps[i]);
                    check("burst_penable", 32'(penable), exp_pe[i]);
                end
            end
            begin
                issue(1'b0, 32'h1000_0000, 32'h0, HTRANS_SEQ, 1'b1, 32'h2222_0001, HRESP_OKAY);
                issue(1'b1, 32'h2000_0008, 32'h1234_5678, HTRANS_SEQ, 1'b1, 32'h0, HRESP_OKAY);
            end
        join
        check("burst_pwdata", pwdata, 32'h1234_5678);
        check("burst_paddr", paddr, 32'h2000_0008);
        repeat (2) @(posedge hclk);
        #1;

        // Decode miss: slave 5 does not exist
`ifdef AHB_APB_ERR_RESP_EN
        issue(1'b0, 32'h5000_0000, 32'h0, HTRANS_NONSEQ, 1'b1, 32'h0, HRESP_ERROR);
        @(negedge hclk);
        check("miss_err1_psel", 32'(psel), 32'd0);
        check("miss_err1_hready", 32'(hready_o), 32'd0);
        check("miss_err1_hresp", 32'(hresp), 32'd1);
        @(negedge hclk);
        check("miss_err2_psel", 32'(psel), 32'd0);
        check("miss_err2_hready", 32'(hready_o), 32'd1);
        check("miss_err2_hresp", 32'(hresp), 32'd1);
`else
        issue(1'b0, 32'h5000_0000, 32'h0, HTRANS_NONSEQ, 1'b1, 32'h0, HRESP_OKAY);
        @(negedge hclk);
        check("miss_psel", 32'(psel), 32'd0);
        check("miss_hready", 32'(hready_o), 32'd1);
        check("miss_hresp", 32'(hresp), 32'd0);
        @(negedge hclk);
        check("miss_psel_after", 32'(psel), 32'd0);
`endif
        repeat (2) @(posedge hclk);
        #1;

        // Slave error on a read from slave 2
        pslverr = 4'b0100;
`ifdef AHB_APB_ERR_RESP_EN
        issue(1'b0, 32'h2000_0000, 32'h0, HTRANS_NONSEQ, 1'b1, 32'h0, HRESP_ERROR);
        @(negedge hclk);
        @(negedge hclk);
        check("slverr_access_hready", 32'(hready_o), 32'd0);
        check("slverr_access_hresp", 32'(hresp), 32'd0);
        @(negedge hclk);
        check("slverr_err1_hready", 32'(hready_o), 32'd0);
        check("slverr_err1_hresp", 32'(hresp), 32'd1);
        @(negedge hclk);
        check("slverr_err2_hready", 32'(hready_o), 32'd1);
        check("slverr_err2_hresp", 32'(hresp), 32'd1);
`else
        issue(1'b0, 32'h2000_0000, 32'h0, HTRANS_NONSEQ, 1'b1, 32'h3333_0002, HRESP_OKAY);
        @(negedge hclk);
        @(negedge hclk);
        check("slverr_ignored_hready", 32'(hready_o), 32'd1);
        check("slverr_ignored_hresp", 32'(hresp), 32'd0);
`endif
        pslverr = 4'h0;
        repeat (2) @(posedge hclk);
        #1;

        // Reset while an access to slave 0 is stalled
        pready = 4'b1110;
        issue(1'b0, 32'h0000_0040, 32'h0, HTRANS_NONSEQ, 1'b0, 32'h0, HRESP_OKAY);
        @(negedge hclk);
        @(negedge hclk);
        check("rstacc_penable_before", 32'(penable), 32'd1);
        @(posedge hclk);
        #1;
        hrst = 1'b1;
        @(posedge hclk);
        #1;
        hrst = 1'b0;
        @(negedge hclk);
        check("rstacc_psel", 32'(psel), 32'd0);
        check("rstacc_penable", 32'(penable), 32'd0);
        check("rstacc_hready", 32'(hready_o), 32'd1);
        check("rstacc_hresp", 32'(hresp), 32'd0);
        check("rstacc_paddr", paddr, 32'd0);
        pready = 4'hF;
        @(posedge hclk);
        #1;
        issue(1'b0, 32'h3000_0000, 32'h0, HTRANS_NONSEQ, 1'b1, 32'hA5A5_0001, HRESP_OKAY);
        @(negedge hclk);
        check("post_rst_psel", 32'(psel), 32'h8);

        repeat (4) @(negedge hclk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning HADDR/PADDR width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning HWDATA/HRDATA/PWDATA width per slave.
REQ-003 SHALL have parameter NUM_SLV, default 16, range 1..16, meaning number of APB slaves.
REQ-004 SHALL have parameter SEL_LSB, default 28, meaning slave index = HADDR[SEL_LSB+3:SEL_LSB].
REQ-005 SHALL have ports:
- HCLK in 1: clock; one clock.
- HRST in 1: reset, synchronous, active-high.
- HSEL, HWRITE, HREADY in 1 each: AHB select, direction, bus ready.
- HTRANS in 2: AHB transfer type.
- HADDR in ADDR_W, HWDATA in DATA_W: AHB address, write data.
- HREADY_o out 1, HRESP out 2, HRDATA out DATA_W: AHB response.
- PADDR out ADDR_W, PWDATA out DATA_W, PWRITE out 1, PENABLE out 1: APB request.
- PSEL out NUM_SLV: one-hot slave select.
- PRDATA in NUM_SLV*DATA_W: slave i read data at [i*DATA_W +: DATA_W].
- PREADY in NUM_SLV, PSLVERR in NUM_SLV: per-slave ready, error.

Function
REQ-006 Transfer SHALL be accepted when HSEL & HREADY & HTRANS is NONSEQ or SEQ; HADDR, HWRITE and decoded index are registered on acceptance.
REQ-007 FSM states SHALL be IDLE, WAIT, SETUP, ACCESS, ERR1, ERR2.
REQ-008 IDLE/ACCESS-complete/ERR2 with acceptance: write -> WAIT, read -> SETUP, index >= NUM_SLV -> ERR1 (macro on) or IDLE (macro off); no acceptance -> IDLE.
REQ-009 WAIT SHALL register HWDATA into PWDATA, then -> SETUP (writes take one extra cycle).
REQ-010 SETUP SHALL drive PSEL[index]=1, PENABLE=0, PADDR/PWRITE from registers, then -> ACCESS.
REQ-011 ACCESS SHALL drive PSEL[index]=1, PENABLE=1 and hold all APB outputs until PREADY[index]=1; unlimited wait states.
REQ-012 HREADY_o SHALL be combinational: 1 in IDLE and ERR2, PREADY[index] & ~error in ACCESS, 0 in WAIT, SETUP, ERR1.
REQ-013 HRDATA SHALL be the PRDATA slice of the registered index; zero in IDLE, ERR1, ERR2 and on decode miss.
REQ-014 Read latency: accept cycle N, SETUP N+1, ACCESS N+2, HREADY_o=1 at N+2 when slave ready with zero waits; write completes at N+3.
REQ-015 Back-to-back transfers SHALL be accepted in the completing ACCESS cycle with no idle APB cycle beyond the mandatory SETUP.
REQ-016 PSEL SHALL be all-zero outside SETUP/ACCESS; never more than one bit set.
REQ-017 HRESP SHALL be OKAY except ERR1/ERR2 (ERROR).

Reset
REQ-018 HRST SHALL force IDLE at next HCLK edge and clear PADDR, PWDATA, PWRITE, PENABLE, PSEL, registered index; HREADY_o=1, HRESP=OKAY, even mid-ACCESS (the APB transfer is abandoned).

Configuration
REQ-019 With AHB_APB_ERR_RESP_EN defined, PSLVERR[index] sampled with PREADY in ACCESS and decode misses SHALL produce the two-cycle ERROR response ERR1 -> ERR2.
REQ-020 Without AHB_APB_ERR_RESP_EN, PSLVERR SHALL be ignored, ERR1/ERR2 unreachable, decode miss completes OKAY with HRDATA=0.

Structure
REQ-021 HTRANS and HRESP encodings and FSM state encodings SHALL live in the shared AHB package.
REQ-022 Address decode (index, miss flag, one-hot) SHALL be sub-module ahb_apb_dec.

Verification
REQ-023 Read HADDR=0x3000_0010, PRDATA slice3=0xA5A5_0001, PREADY=1 -> PSEL=0x0008 at N+1, HREADY_o=1 and HRDATA=0xA5A5_0001 at N+2.
REQ-024 Write 0x1000_0004 data 0xDEAD_BEEF, PREADY low 3 cycles -> PWDATA=0xDEAD_BEEF, PENABLE high 4 cycles, HREADY_o low until PREADY.
REQ-025 Burst read, read, write to slaves 0,1,2 -> no idle cycle between reads, WAIT inserted before write.
REQ-026 Macro on, PSLVERR[2]=1 on read -> HRESP=ERROR two cycles, HREADY_o 0 then 1; NUM_SLV=4 access 0x5000_0000 -> ERROR, PSEL=0.
REQ-027 HRST asserted during ACCESS -> next cycle PSEL=0, PENABLE=0, HREADY_o=1, state IDLE.
